crc9_serial_checker: RTL and testbench
======================================

Name: crc9_serial_checker

Overview:
- Receive-side counterpart of the serial CRC-9 encoder (generator g(y) = 1 + y + y^8 + y^9, 10-bit message, 9-bit check field).
- Accepts a 19-bit codeword serially, MSB first: 10 data bits followed by 9 CRC bits.
- Divides the codeword by g with an LFSR, then reports the recovered data, the syndrome, and a pass/fail flag.
- Sits after the serial link / deserializer front end and ahead of the message consumer.

Parameters:
- DATA_W, 10, message width in bits.
- CRC_W, 9, check-field width in bits.
- POLY, 9'h103, generator coefficients y^8..y^0; the y^9 term is implicit.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- frame_start  input  1  marks the first bit of a codeword; qualified by bit_valid.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial codeword bit, MSB first.
- busy  output  1  high while a frame is being received.
- done  output  1  one-cycle pulse when a frame completes.
- data_out  output  DATA_W  recovered message bits; held until the next done.
- syndrome  output  CRC_W  remainder of codeword mod g; held until the next done.
- crc_err  output  1  high when syndrome != 0; held until the next done.
- frame_abort  output  1  one-cycle pulse when a new frame_start interrupts a frame in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs busy, done, crc_err and frame_abort go to 0.
  - data_out and syndrome go to 0.
  - Internal registers (LFSR, bit counter, FSM) are cleared and the FSM goes to IDLE.
  - Reset mid-frame discards the partial frame with no done pulse.
- FSM states: IDLE, RECV, DONE.
- IDLE:
  - bit_valid && frame_start: bit accepted as bit 0, go to RECV.
  - bit_valid without frame_start: bit ignored.
- Per accepted bit b:
  - lfsr <= {lfsr[CRC_W-2:0], b} ^ (lfsr[CRC_W-1] ? POLY : 0).
  - lfsr is cleared to 0 before bit 0.
  - Bits 0..DATA_W-1 also shift into a data shift register, MSB first.
- Bit counter (5 bits) counts accepted bits 0..18.
- bit_valid low in RECV stalls the frame; no timeout.
- The 19th accepted bit moves the FSM to DONE.
- DONE lasts exactly one cycle:
  - done=1.
  - data_out, syndrome (= final lfsr) and crc_err are registered.
  - Next state is IDLE.
- Latency: done asserts 1 cycle after the 19th bit is sampled.
- busy=1 in RECV only.
- A bit presented in the DONE cycle is ignored, even with frame_start set.
- frame_start && bit_valid during RECV:
  - frame_abort pulses.
  - The counter and LFSR restart, and this bit is taken as bit 0 of the new frame.
  - Outputs from the previous completed frame are unchanged.
- With the encoder's convention (codeword = data*y^9 + (data*y^9 mod g)), an error-free frame gives syndrome = 0.
- For any received frame, syndrome = received CRC field XOR CRC recomputed from the received data.

Optional Feature:
- Macro: CRC9_CHK_ERR_CNT_EN.
- When defined:
  - Adds output err_count [7:0], cleared by reset.
  - err_count increments on each done with crc_err=1 and saturates at 8'hFF.
  - Aborted frames are not counted.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package crc9_pkg holds:
  - DATA_W, CRC_W, FRAME_LEN (=19) and POLY.
  - The FSM state enum {IDLE, RECV, DONE}.
- Sub-module crc9_lfsr_div is the one-bit division step, shared with future parallel variants.
  - Inputs: en, clr, b.
  - Output: lfsr state.

Test Plan:
- Error-free, minimal data: data 10'h001, CRC 9'h103 (codeword 0000000001_100000011) -> done one cycle after the last bit, syndrome=0, crc_err=0, data_out=10'h001.
- Error-free, single high bit: data 10'h200, CRC 9'h004 -> syndrome=0, crc_err=0, data_out=10'h200.
- Corrupt CRC field: data 10'h200, CRC 9'h000 -> syndrome=9'h004, crc_err=1; with CRC9_CHK_ERR_CNT_EN, err_count=1.
- Stalls: the same frame as the first test with bit_valid low for 3 random cycles between bits -> identical result; busy high throughout the frame; done width 1.
- Abort: frame_start after 7 bits, then a full frame of data 10'h000 / CRC 9'h000 -> frame_abort pulses once, a single done follows, syndrome=0.
- Reset mid-frame: assert reset after bit 12 -> no done, all outputs 0; the next full error-free frame passes normally.

Source files
------------

// File: rtl/crc9_pkg.sv
// rtl/crc9_pkg.sv - shared constants, FSM state type and one-bit CRC-9 division step.
package crc9_pkg;

  localparam int DATA_W    = 10;
  localparam int CRC_W     = 9;
  localparam int FRAME_LEN = DATA_W + CRC_W;
  localparam int CNT_W     = 5;

  // Generator 1 + y + y^8 + y^9; the y^9 term is implicit in the shift-out.
  localparam logic [CRC_W-1:0] POLY = 9'h103;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_e;

  function automatic logic [CRC_W-1:0] crc9_step(input logic [CRC_W-1:0] s, input logic b);
    return {s[CRC_W-2:0], b} ^ (s[CRC_W-1] ? POLY : '0);
  endfunction

endpackage

// File: rtl/crc9_lfsr_div.sv
// rtl/crc9_lfsr_div.sv - one-bit-per-cycle polynomial division register for CRC-9.
// clr together with en restarts division with b as the first codeword bit.
module crc9_lfsr_div
  import crc9_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             b,
  output logic [CRC_W-1:0] lfsr_o,
  output logic [CRC_W-1:0] lfsr_next_o
);

  logic [CRC_W-1:0] lfsr_q;
  logic [CRC_W-1:0] lfsr_d;
  logic [CRC_W-1:0] base;

  assign base        = clr ? '0 : lfsr_q;
  assign lfsr_next_o = crc9_step(base, b);

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = lfsr_next_o;
    end else if (clr) begin
      lfsr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/crc9_serial_checker.sv
// rtl/crc9_serial_checker.sv - serial CRC-9 frame checker (10 data + 9 CRC bits, MSB first).
// Optional saturating error counter output err_count under CRC9_CHK_ERR_CNT_EN.
module crc9_serial_checker
  import crc9_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  syndrome,
  output logic              crc_err,
  output logic              frame_abort
`ifdef CRC9_CHK_ERR_CNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] data_out_q;
  logic [CRC_W-1:0]  syndrome_q;
  logic              crc_err_q;
  logic              abort_q, abort_d;
  logic              lfsr_en, lfsr_clr;
  logic              capture;
  logic [CRC_W-1:0]  lfsr_cur;
  logic [CRC_W-1:0]  lfsr_next;
  logic [DATA_W-1:0] data_shift;

  assign data_shift = {data_q[DATA_W-2:0], bit_in};

  crc9_lfsr_div u_div (
    .clk         (clk),
    .rst         (reset),
    .en          (lfsr_en),
    .clr         (lfsr_clr),
    .b           (bit_in),
    .lfsr_o      (lfsr_cur),
    .lfsr_next_o (lfsr_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    lfsr_en  = 1'b0;
    lfsr_clr = 1'b0;
    capture  = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_valid && frame_start) begin
          state_d  = RECV;
          lfsr_en  = 1'b1;
          lfsr_clr = 1'b1;
          cnt_d    = CNT_W'(1);
          data_d   = data_shift;
        end
      end
      RECV: begin
        if (bit_valid) begin
          lfsr_en = 1'b1;
          if (frame_start) begin
            // A fresh start wins even on what would have been the last bit.
            abort_d  = 1'b1;
            lfsr_clr = 1'b1;
            cnt_d    = CNT_W'(1);
            data_d   = data_shift;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q < CNT_W'(DATA_W)) begin
              data_d = data_shift;
            end
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
              state_d = DONE;
              capture = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Results are captured on the last bit so they are already valid while done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      syndrome_q <= '0;
      crc_err_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      if (capture) begin
        data_out_q <= data_q;
        syndrome_q <= lfsr_next;
        crc_err_q  <= |lfsr_next;
      end
    end
  end

`ifdef CRC9_CHK_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (capture && (|lfsr_next) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign busy        = (state_q == RECV);
  assign done        = (state_q == DONE);
  assign data_out    = data_out_q;
  assign syndrome    = syndrome_q;
  assign crc_err     = crc_err_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_crc9_serial_checker.sv
// tb/tb_crc9_serial_checker.sv - randomized self-checking bench against a long-division CRC-9 model.
module tb_crc9_serial_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       busy;
  logic       done;
  logic [9:0] data_out;
  logic [8:0] syndrome;
  logic       crc_err;
  logic       frame_abort;
`ifdef CRC9_CHK_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  crc9_serial_checker dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .syndrome    (syndrome),
    .crc_err     (crc_err),
    .frame_abort (frame_abort)
`ifdef CRC9_CHK_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int exp_err_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Remainder of the 19-bit codeword polynomial divided by y^9 + y^8 + y + 1.
  function automatic logic [8:0] mod_g(input logic [18:0] cw);
    logic [18:0] r;
    logic [18:0] g;
    r = cw;
    g = 19'h303;
    for (int i = 18; i >= 9; i--) begin
      if (r[i]) r = r ^ (g << (i - 9));
    end
    return r[8:0];
  endfunction

  function automatic logic [18:0] make_cw(input logic [9:0] d);
    return {d, mod_g({d, 9'b0})};
  endfunction

  task automatic send_bits(input logic [18:0] cw, input int first, input int last,
                           input int max_stall, inout int busy_low);
    for (int i = first; i < last; i++) begin
      if (i > 0) begin
        int ns;
        ns = $urandom_range(max_stall, 0);
        for (int s = 0; s < ns; s++) begin
          @(negedge clk);
          if (busy !== 1'b1) busy_low++;
          frame_start = 1'($urandom_range(1, 0));
          bit_valid   = 1'b0;
          bit_in      = 1'($urandom_range(1, 0));
        end
      end
      @(negedge clk);
      if (i > 0 && busy !== 1'b1) busy_low++;
      frame_start = (i == 0);
      bit_valid   = 1'b1;
      bit_in      = cw[18-i];
    end
  endtask

  task automatic finish_frame(input logic [18:0] cw, input int d0, input int busy_low,
                              input string tag);
    logic [8:0] syn;
    syn = mod_g(cw);
    @(negedge clk);
    frame_start = 1'b1;
    bit_valid   = 1'b1;
    bit_in      = 1'($urandom_range(1, 0));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(cw[18:9]));
    chk({tag, "_syn"}, 32'(syndrome), 32'(syn));
    chk({tag, "_err"}, 32'(crc_err), 32'(syn != 9'd0));
`ifdef CRC9_CHK_ERR_CNT_EN
    if (syn != 9'd0 && exp_err_cnt < 255) exp_err_cnt++;
    chk({tag, "_errcnt"}, 32'(err_count), 32'(exp_err_cnt));
`endif
    @(negedge clk);
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    chk({tag, "_done_w"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_busy"}, 32'(busy_low), 32'd0);
    chk({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic run_frame(input logic [18:0] cw, input int max_stall, input string tag);
    int d0;
    int bl;
    d0 = done_cnt;
    bl = 0;
    send_bits(cw, 0, 19, max_stall, bl);
    finish_frame(cw, d0, bl, tag);
  endtask

  initial begin
    logic [18:0] cw;
    logic [18:0] cw_a;
    logic [9:0]  prev_data;
    logic [8:0]  prev_syn;
    int          d0;
    int          a0;
    int          bl;

    @(negedge clk);
    chk("rst_outs", {busy, done, crc_err, frame_abort, data_out, syndrome}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_frame(19'b0000000001_100000011, 0, "min");
    run_frame(make_cw(10'h200), 0, "hi");
    chk("hi_crc_const", 32'(mod_g({10'h200, 9'b0})), 32'h004);
    run_frame({10'h200, 9'h000}, 0, "corrupt");
    run_frame(19'b0000000001_100000011, 3, "stall");

    // Abort: 7 bits of one frame, then a restarting all-zero frame.
    prev_data = data_out;
    prev_syn  = syndrome;
    cw_a = make_cw(10'($urandom));
    d0 = done_cnt;
    a0 = abort_cnt;
    bl = 0;
    send_bits(cw_a, 0, 7, 0, bl);
    send_bits(19'h0, 0, 1, 0, bl);
    @(negedge clk);
    bit_valid = 1'b0;
    frame_start = 1'b0;
    chk("abort_pulse", 32'(frame_abort), 32'd1);
    chk("abort_hold", {13'd0, prev_data, prev_syn}, {13'd0, data_out, syndrome});
    send_bits(19'h0, 1, 19, 0, bl);
    finish_frame(19'h0, d0, bl, "abort");
    chk("abort_cnt", 32'(abort_cnt - a0), 32'd1);

    // Reset after bit 12 drops the partial frame.
    d0 = done_cnt;
    bl = 0;
    send_bits(make_cw(10'h155), 0, 13, 1, bl);
    @(negedge clk);
    bit_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {busy, done, crc_err, frame_abort, data_out, syndrome}, 32'd0);
`ifdef CRC9_CHK_ERR_CNT_EN
    exp_err_cnt = 0;
    chk("mid_rst_errcnt", 32'(err_count), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_nodone", 32'(done_cnt - d0), 32'd0);
    run_frame(make_cw(10'h2A7), 0, "post_rst");

    for (int n = 0; n < 24; n++) begin
      cw = make_cw(10'($urandom));
      case ($urandom_range(2, 0))
        0: cw = cw ^ (19'd1 << $urandom_range(18, 0));
        1: cw = cw ^ 19'($urandom);
        default: ;
      endcase
      run_frame(cw, $urandom_range(2, 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
